// File: rtl/regfile_mp.sv
// Multi-port register file with a pending scoreboard; zero-cycle reads, writes land at the next edge, no backpressure.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*WIDTH-1:0] rdata,
  output logic [NRD-1:0]       rready,
  input  logic [NWR-1:0]       wen,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NWR*WIDTH-1:0] wdata,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  output logic [DEPTH-1:0]     pending
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_pending;
  logic [DEPTH-1:0] w_pending_nxt;
  logic [AW-1:0]    w_ra;

  // Write clears first, then alloc sets, so alloc wins on the same address.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int j = 0; j < NWR; j++) begin
      if (wen[j]) w_pending_nxt[waddr[j*AW +: AW]] = 1'b0;
    end
    if (alloc_en) w_pending_nxt[alloc_addr] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pending <= '0;
    else      r_pending <= w_pending_nxt;
  end

  // Later loop iterations override earlier ones: highest-index port wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wen[j] && (waddr[j*AW +: AW] != '0))
          r_mem[waddr[j*AW +: AW]] <= wdata[j*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    rdata  = '0;
    rready = '1;
    w_ra   = '0;
    for (int i = 0; i < NRD; i++) begin
      w_ra = raddr[i*AW +: AW];
      // Reset gating keeps a live write port from bypassing into the outputs.
      if (rst && (w_ra != '0)) begin
        rdata[i*WIDTH +: WIDTH] = r_mem[w_ra];
        rready[i]               = ~r_pending[w_ra];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++) begin
          if (wen[j] && (waddr[j*AW +: AW] == w_ra)) begin
            rdata[i*WIDTH +: WIDTH] = wdata[j*WIDTH +: WIDTH];
            rready[i]               = 1'b1;
          end
        end
`else
`endif
      end
    end
  end

  assign pending = r_pending;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp at default parameters; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_mp;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2*AW-1:0] raddr = '0;
  logic [2*W-1:0]  rdata;
  logic [1:0]      rready;
  logic [1:0]      wen = '0;
  logic [2*AW-1:0] waddr = '0;
  logic [2*W-1:0]  wdata = '0;
  logic            alloc_en = 1'b0;
  logic [AW-1:0]   alloc_addr = '0;
  logic [D-1:0]    pending;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NRD(2), .NWR(2)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rready(rready),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;   // 0 rdata, 1 rready, 2 pending
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_mem [D];
  logic [D-1:0] m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input int port, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.port = port; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       got = rdata[e.port*W +: W];
        1:       got = {31'b0, rready[e.port]};
        default: got = pending;
      endcase
      check(e.tag, got, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int j, input logic en, input logic [AW-1:0] a, input logic [31:0] d);
    wen[j]           = en;
    waddr[j*AW +: AW] = a;
    wdata[j*W +: W]   = d;
  endtask

  task automatic idle();
    wen = '0;
    alloc_en = 1'b0;
  endtask

  // Reference read of one port from the model plus current stimulus.
  task automatic model_read(input int i, output logic [31:0] d, output logic r);
    logic [AW-1:0] a;
    a = raddr[i*AW +: AW];
    d = (a == '0) ? 32'h0 : m_mem[a];
    r = (a == '0) ? 1'b1 : ~m_pend[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < 2; j++) begin
      if (wen[j] && waddr[j*AW +: AW] == a && a != '0) begin
        d = wdata[j*W +: W];
        r = 1'b1;
      end
    end
`endif
  endtask

  task automatic model_edge();
    for (int j = 0; j < 2; j++) begin
      if (wen[j]) begin
        if (waddr[j*AW +: AW] != '0) m_mem[waddr[j*AW +: AW]] = wdata[j*W +: W];
        m_pend[waddr[j*AW +: AW]] = 1'b0;
      end
    end
    if (alloc_en) m_pend[alloc_addr] = 1'b1;
    m_pend[0] = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        r;
    logic [31:0] byp_exp;
    for (int k = 0; k < D; k++) m_mem[k] = '0;
    m_pend = '0;

    // Reset held with live writes and allocs: outputs forced quiet.
    set_wr(0, 1'b1, 5'd3, 32'hCAFE0001);
    set_wr(1, 1'b1, 5'd4, 32'hCAFE0002);
    alloc_en = 1'b1; alloc_addr = 5'd3;
    raddr = {5'd4, 5'd3};
    #13;
    push("rst_rdata0", 0, 0, 32'h0);
    push("rst_rdata1", 0, 1, 32'h0);
    push("rst_rready", 1, 0, 32'h1);
    push("rst_rready1", 1, 1, 32'h1);
    push("rst_pending", 2, 0, 32'h0);
    drain();
    idle();
    @(negedge clk);
    rst = 1'b1;
    step();

    // Writes to register 0 are dropped; alloc of 0 is ignored.
    set_wr(0, 1'b1, 5'd0, 32'h12345678);
    alloc_en = 1'b1; alloc_addr = 5'd0;
    step();
    idle();
    raddr = {5'd0, 5'd0};
    #3;
    push("r0_data", 0, 0, 32'h0);
    push("r0_rdy", 1, 0, 32'h1);
    push("r0_pend", 2, 0, 32'h0);
    drain();

    // Two ports to the same address: port 1 wins.
    step();
    set_wr(0, 1'b1, 5'd1, 32'h11111111);
    set_wr(1, 1'b1, 5'd1, 32'h33333333);
    step();
    idle();
    raddr = {5'd0, 5'd1};
    #3;
    push("wr_prio", 0, 0, 32'h33333333);
    drain();

    // Same-cycle read of a register being written.
    step();
    raddr = {5'd0, 5'd2};
    set_wr(0, 1'b1, 5'd2, 32'h22222222);
`ifdef REGFILE_BYPASS_EN
    byp_exp = 32'h22222222;
`else
    byp_exp = 32'h0;
`endif
    #3;
    push("byp_data", 0, 0, byp_exp);
    push("byp_rdy", 1, 0, 32'h1);
    drain();
    step();
    idle();
    #3;
    push("byp_after", 0, 0, 32'h22222222);
    drain();

    // Alloc then producer write on register 5.
    step();
    alloc_en = 1'b1; alloc_addr = 5'd5;
    raddr = {5'd5, 5'd0};
    #3;
    push("alloc_same_rdy", 1, 1, 32'h1);
    drain();
    step();
    idle();
    #3;
    push("alloc_pend", 2, 0, 32'h20);
    push("alloc_rdy", 1, 1, 32'h0);
    drain();
    step();
    set_wr(0, 1'b1, 5'd5, 32'hA5A5A5A5);
`ifdef REGFILE_BYPASS_EN
    byp_exp = 32'hA5A5A5A5;
`else
    byp_exp = 32'h0;
`endif
    #3;
    push("prod_same_data", 0, 1, byp_exp);
    push("prod_same_rdy", 1, 1, {31'b0, byp_exp != 32'h0});
    drain();
    step();
    idle();
    #3;
    push("prod_pend", 2, 0, 32'h0);
    push("prod_data", 0, 1, 32'hA5A5A5A5);
    push("prod_rdy", 1, 1, 32'h1);
    drain();

    // Alloc beats a same-cycle write clear; data still stored.
    step();
    alloc_en = 1'b1; alloc_addr = 5'd7;
    set_wr(1, 1'b1, 5'd7, 32'h5);
    step();
    idle();
    raddr = {5'd7, 5'd0};
    #3;
    push("alloc_win_pend", 2, 0, 32'h80);
    push("alloc_win_data", 0, 1, 32'h5);
    push("alloc_win_rdy", 1, 1, 32'h0);
    drain();

    // Build pending=0xA0 with reg3=all-ones, then reset between edges.
    step();
    alloc_en = 1'b1; alloc_addr = 5'd5;
    set_wr(0, 1'b1, 5'd3, 32'hFFFFFFFF);
    step();
    idle();
    raddr = {5'd5, 5'd3};
    #3;
    push("pre_rst_pend", 2, 0, 32'hA0);
    push("pre_rst_r3", 0, 0, 32'hFFFFFFFF);
    drain();
    step();
    set_wr(0, 1'b1, 5'd3, 32'h0000DEAD);
    alloc_en = 1'b1; alloc_addr = 5'd9;
    #1;
    rst = 1'b0;
    #1;
    push("mid_rst_pend", 2, 0, 32'h0);
    push("mid_rst_r3", 0, 0, 32'h0);
    push("mid_rst_rdy1", 1, 1, 32'h1);
    drain();
    #1;
    rst = 1'b1;
    step();
    idle();
    #3;
    push("post_rst_wr", 0, 0, 32'h0000DEAD);
    push("post_rst_pend", 2, 0, 32'h200);
    push("post_rst_r5", 0, 1, 32'h0);
    drain();

    // Randomised traffic against the model, with addresses clustered to force collisions.
    for (int k = 0; k < D; k++) m_mem[k] = '0;
    m_mem[3] = 32'h0000DEAD;
    m_pend = '0;
    m_pend[9] = 1'b1;
    for (int c = 0; c < 400; c++) begin
      step();
      for (int j = 0; j < 2; j++)
        set_wr(j, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 11)), $urandom);
      alloc_en   = 1'($urandom_range(0, 2) == 0);
      alloc_addr = 5'($urandom_range(0, 11));
      raddr      = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
      for (int i = 0; i < 2; i++) begin
        model_read(i, d, r);
        push("rnd_data", 0, i, d);
        push("rnd_rdy", 1, i, {31'b0, r});
      end
      push("rnd_pend", 2, 0, m_pend);
      #3;
      drain();
      model_edge();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
